tinychip_mc_controller: RTL

Parametrised multi-cycle controller for the TinyChip 9-bit ISA, replacing the single-always-block controller with an explicit FETCH/EXEC/MEM/HALT state machine. It contains the 4-entry register file and ALU, fetches from an external instruction memory, and drives a request/acknowledge data-memory port. It resolves branches and jumps: taken branches and jumps load the PC. It also reports a one-cycle retire pulse per instruction.

---
 rtl/tinychip_mc_controller.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/tinychip_mc_controller.sv
// -----------------------------------------------------------------------------
// tinychip_mc_controller
//
// Multi-cycle controller for the TinyChip 9-bit ISA. Holds the 4-entry
// register file, the ALU and the program counter, fetches from an external
// combinational instruction memory and talks to data memory through a
// request/acknowledge handshake. Sequencing is an explicit
// FETCH -> EXEC -> (MEM) -> FETCH state machine with an absorbing HALT state.
//
// Ports
//   clk         clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   imem_addr   instruction address (current PC)
//   imem_instr  instruction word at imem_addr
//   imem_done   end-of-program flag for imem_addr
//   dmem_req    data-memory request, held until dmem_ack
//   dmem_we     1 = store, 0 = load (valid while dmem_req)
//   dmem_addr   data-memory address
//   dmem_wdata  store data
//   dmem_rdata  load data, valid with dmem_ack
//   dmem_ack    one-cycle completion strobe
//   retired     one-cycle pulse after each instruction completes
//   done        high once the controller has halted
// -----------------------------------------------------------------------------
module tinychip_mc_controller #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [8:0]         imem_instr,
  input  logic               imem_done,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               retired,
  output logic               done
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Architectural and control state
  state_t               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [8:0]           ir_q;
  logic [DATA_W-1:0]    rf_q [4];
  logic                 req_q;
  logic                 we_q;
  logic [DADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 retired_q;
  logic                 done_q;

  // Instruction fields
  logic                 ir_bt;
  logic [2:0]           ir_op;
  logic [1:0]           ir_rd;
  logic [1:0]           ir_ro;
  logic                 ir_fn;
  logic [DATA_W-1:0]    opa;
  logic [DATA_W-1:0]    opb;
  logic [DATA_W-1:0]    imm;
  logic [PC_W-1:0]      pc_inc;

  // EXEC-stage next-state values
  logic                 rf_we_d;
  logic [DATA_W-1:0]    rf_wdata_d;
  logic [PC_W-1:0]      pc_d;
  logic                 mem_go_d;
  logic                 mem_we_d;
  logic [DADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_d;

  // Register value to PC width; zero-extends when PC_W exceeds DATA_W.
  function automatic logic [PC_W-1:0] to_pc(input logic [DATA_W-1:0] v);
    logic [PC_W+DATA_W-1:0] ext;
    ext = {{PC_W{1'b0}}, v};
    return ext[PC_W-1:0];
  endfunction

  // Register value to data-memory address width (low bits).
  function automatic logic [DADDR_W-1:0] to_daddr(input logic [DATA_W-1:0] v);
    return v[DADDR_W-1:0];
  endfunction

  assign ir_bt  = ir_q[8];
  assign ir_op  = ir_q[7:5];
  assign ir_rd  = ir_q[4:3];
  assign ir_ro  = ir_q[2:1];
  assign ir_fn  = ir_q[0];

  // Operands are read from the current register contents, so an instruction
  // whose destination is also its source sees the old value.
  assign opa    = rf_q[ir_rd];
  assign opb    = rf_q[ir_ro];
  assign imm    = {{(DATA_W-3){1'b0}}, ir_q[2:0]};
  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // Instruction decode and ALU
  always_comb begin
    rf_we_d     = 1'b0;
    rf_wdata_d  = '0;
    pc_d        = pc_inc;
    mem_go_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = to_daddr(opb);
    mem_wdata_d = opb;
    if (ir_bt) begin
      case (ir_op)
        3'b000: begin
          rf_we_d    = 1'b1;
          rf_wdata_d = opa + imm;
        end
        3'b001: begin
          rf_we_d    = 1'b1;
          rf_wdata_d = opa - imm;
        end
        3'b010: if (opa == imm) pc_d = to_pc(rf_q[3]);
        3'b011: if (opa != imm) pc_d = to_pc(rf_q[3]);
        3'b100: begin
          mem_go_d   = 1'b1;
          mem_addr_d = to_daddr(opb);
        end
        3'b101: begin
          mem_go_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = to_daddr(opa);
          mem_wdata_d = opb;
        end
        3'b110: begin
          rf_we_d    = 1'b1;
          rf_wdata_d = opa >> ir_q[2:0];
        end
        default: begin
          rf_we_d    = 1'b1;
          rf_wdata_d = opa << ir_q[2:0];
        end
      endcase
    end else if (ir_fn && ir_op == 3'b000) begin
      // Register-indirect jump
      pc_d = to_pc(opb);
    end else if (ir_fn && ir_op == 3'b101) begin
      // Clear destination register
      rf_we_d    = 1'b1;
      rf_wdata_d = '0;
    end else begin
      rf_we_d = 1'b1;
      case (ir_op)
        3'b000:  rf_wdata_d = opa + opb;
        3'b001:  rf_wdata_d = opa - opb;
        3'b010:  rf_wdata_d = opa & opb;
        3'b011:  rf_wdata_d = opa | opb;
        3'b100:  rf_wdata_d = opa ^ opb;
        3'b101:  rf_wdata_d = opa * opb;
        3'b110:  rf_wdata_d = opa >> opb[3:0];
        default: rf_wdata_d = opa << opb[3:0];
      endcase
    end
  end

  // Controller state machine; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      retired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      retired_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (imem_done) begin
            state_q <= HALT;
            done_q  <= 1'b1;
          end else begin
            ir_q    <= imem_instr;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (mem_go_d) begin
            req_q   <= 1'b1;
            we_q    <= mem_we_d;
            addr_q  <= mem_addr_d;
            wdata_q <= mem_wdata_d;
            state_q <= MEM;
          end else begin
            if (rf_we_d) rf_q[ir_rd] <= rf_wdata_d;
            pc_q      <= pc_d;
            retired_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        MEM: begin
          // Address/data stay put until the ack so the memory sees a stable
          // request for the whole handshake.
          if (dmem_ack) begin
            req_q <= 1'b0;
            if (!we_q) rf_q[ir_rd] <= dmem_rdata;
            pc_q      <= pc_inc;
            retired_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        default: begin
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign retired    = retired_q;
  assign done       = done_q;

endmodule
